// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: runs one req/gnt/rvalid data-memory access per
// instruction, stalls the pipeline meanwhile and returns aligned, extended load data.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic        is_load_i,
    input  logic        mem_wren_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] ld_data_o,
    output logic        ld_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     ld_data_q, ld_data_d;
    logic            misalign_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [31:0]     addr_q, wdata_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;

    logic            access, legal, aligned, start, bad, timeout;
    logic [3:0]      be_new;
    logic [31:0]     wdata_new, lane, ld_ext;

    // A load with both is_load_i and mem_wren_i set decodes as a load.
    always_comb begin
        legal = 1'b0;
        if (is_load_i) begin
            case (funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end else begin
            legal = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11);
        end

        case (funct3_i[1:0])
            2'b01:   aligned = ~addr_i[0];
            2'b10:   aligned = (addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        case (funct3_i[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << addr_i[1:0];
                wdata_new = {2{st_data_i[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = st_data_i;
            end
        endcase
    end

    assign access  = valid_i & (is_load_i | mem_wren_i);
    assign start   = (state_q == IDLE) & access & legal & aligned;
    assign bad     = (state_q == IDLE) & access & ~(legal & aligned);
    assign timeout = (int'(cnt_q) + 1) >= TIMEOUT_CYCLES;
    assign lane    = dmem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  ld_ext = {24'h0, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  ld_ext = {16'h0, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    // A response that arrives on the timeout cycle still wins over the abort.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        ld_data_d = ld_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_gnt_i) begin
                    state_d = we_q ? DONE : WAIT;
                end else if (timeout) begin
                    state_d   = DONE;
                    err_d     = 1'b1;
                    ld_data_d = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_rvalid_i) begin
                    state_d   = DONE;
                    ld_data_d = ld_ext;
                end else if (timeout) begin
                    state_d   = DONE;
                    err_d     = 1'b1;
                    ld_data_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ld_data_q  <= '0;
            misalign_q <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            off_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ld_data_q  <= ld_data_d;
            misalign_q <= bad;
            if (start) begin
                we_q    <= ~is_load_i;
                be_q    <= be_new;
                addr_q  <= {addr_i[31:2], 2'b00};
                wdata_q <= wdata_new;
                f3_q    <= funct3_i;
                off_q   <= addr_i[1:0];
            end
        end
    end

    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = dmem_req_o & we_q;
    assign dmem_addr_o  = dmem_req_o ? addr_q  : 32'h0;
    assign dmem_be_o    = dmem_req_o ? be_q    : 4'h0;
    assign dmem_wdata_o = dmem_req_o ? wdata_q : 32'h0;
    assign stall_o      = start | (state_q == REQ) | (state_q == WAIT);
    assign ld_data_o    = ld_data_q;
    assign ld_valid_o   = (state_q == DONE) & ~we_q & ~err_q;
    assign bus_err_o    = (state_q == DONE) & err_q;
    assign misalign_o   = misalign_q;

endmodule
